dphy_byte_align: RTL and testbench

DPHY_BYTE_ALIGN -- requirements
Module: dphy_byte_align

---
 rtl/dphy_pkg.sv | 14 +
 rtl/dphy_sync_detect.sv | 32 +++
 rtl/dphy_byte_align.sv | 104 ++++++++++
 tb/tb_dphy_byte_align.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dphy_pkg.sv
// Shared definitions for the D-PHY receive byte path: HS sync pattern and
// the byte aligner state encoding.
package dphy_pkg;

    localparam logic [7:0] HS_SYNC_BYTE = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH  = 2'd1,
        ST_ALIGNED = 2'd2,
        ST_FAIL    = 2'd3
    } align_state_e;

endpackage

// File: rtl/dphy_sync_detect.sv
// Combinational HS sync search over a 16-bit two-byte window; reports the
// lowest bit offset (0..7) at which the sync byte appears.
module dphy_sync_detect
    import dphy_pkg::*;
(
    input  logic [15:0] window_i,
    output logic        match_o,
    output logic [2:0]  offset_o
);

    logic       match_s;
    logic [2:0] offset_s;

    // Scan high to low so the lowest matching offset is the one that sticks
    always_comb begin
        match_s  = 1'b0;
        offset_s = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (window_i[k +: 8] == HS_SYNC_BYTE) begin
                match_s  = 1'b1;
                offset_s = 3'(k);
            end else begin
                match_s  = match_s;
                offset_s = offset_s;
            end
        end
    end

    assign match_o  = match_s;
    assign offset_o = offset_s;

endmodule

// File: rtl/dphy_byte_align.sv
// D-PHY HS byte aligner: locates the sync byte at any bit offset in the
// unaligned lane stream, then emits realigned payload bytes for the burst.
module dphy_byte_align
    import dphy_pkg::*;
#(
    parameter int SYNC_TIMEOUT = 32
) (
    input  logic       byte_clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic [7:0] byte_data_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       sync_found_o,
    output logic       sync_err_o,
    output logic [2:0] offset_o
);

    localparam int                CNT_W        = $clog2(SYNC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT    = CNT_W'(SYNC_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(SYNC_TIMEOUT - 1);

    align_state_e      state_r;
    logic [7:0]        prev_byte_r;
    logic [CNT_W-1:0]  search_cnt_r;
    logic [7:0]        byte_r;
    logic              valid_r;
    logic              sync_found_r;
    logic              sync_err_r;
    logic [2:0]        offset_r;

    logic [15:0]       window_s;
    logic              match_s;
    logic [2:0]        match_off_s;

    // Newest byte in the upper half so stream order runs from bit 0 upward
    assign window_s = {byte_data_i, prev_byte_r};

    dphy_sync_detect u_sync_detect (
        .window_i (window_s),
        .match_o  (match_s),
        .offset_o (match_off_s)
    );

    // Alignment FSM; pulses default low and a dropped enable wins over everything
    always_ff @(posedge byte_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            prev_byte_r  <= 8'h00;
            search_cnt_r <= {CNT_W{1'b0}};
            byte_r       <= 8'h00;
            valid_r      <= 1'b0;
            sync_found_r <= 1'b0;
            sync_err_r   <= 1'b0;
            offset_r     <= 3'd0;
        end else begin
            prev_byte_r  <= byte_data_i;
            valid_r      <= 1'b0;
            sync_found_r <= 1'b0;
            sync_err_r   <= 1'b0;
            if (!enable_i) begin
                state_r      <= ST_IDLE;
                search_cnt_r <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r      <= ST_SEARCH;
                        search_cnt_r <= {CNT_W{1'b0}};
                    end
                    ST_SEARCH: begin
                        if (match_s) begin
                            state_r      <= ST_ALIGNED;
                            offset_r     <= match_off_s;
                            sync_found_r <= 1'b1;
                        end else if (search_cnt_r >= CNT_LAST) begin
                            state_r      <= ST_FAIL;
                            sync_err_r   <= 1'b1;
                            search_cnt_r <= CNT_LIMIT;
                        end else begin
                            search_cnt_r <= search_cnt_r + CNT_W'(1);
                        end
                    end
                    ST_ALIGNED: begin
                        byte_r  <= window_s[offset_r +: 8];
                        valid_r <= 1'b1;
                    end
                    ST_FAIL: begin
                        state_r <= ST_FAIL;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign byte_o       = byte_r;
    assign valid_o      = valid_r;
    assign sync_found_o = sync_found_r;
    assign sync_err_o   = sync_err_r;
    assign offset_o     = offset_r;

endmodule

// File: tb/tb_dphy_byte_align.sv
// Randomized bench for dphy_byte_align against a bit-stream reference model.
module tb_dphy_byte_align;

    localparam int TO = 32;
    localparam int MD_IDLE = 0, MD_SEARCH = 1, MD_ALIGNED = 2, MD_TIMEOUT = 3;

    logic       byte_clk_i = 1'b0;
    logic       rst_i;
    logic       enable_i;
    logic [7:0] byte_data_i;
    logic [7:0] byte_o;
    logic       valid_o;
    logic       sync_found_o;
    logic       sync_err_o;
    logic [2:0] offset_o;

    dphy_byte_align #(.SYNC_TIMEOUT(TO)) dut (
        .byte_clk_i   (byte_clk_i),
        .rst_i        (rst_i),
        .enable_i     (enable_i),
        .byte_data_i  (byte_data_i),
        .byte_o       (byte_o),
        .valid_o      (valid_o),
        .sync_found_o (sync_found_o),
        .sync_err_o   (sync_err_o),
        .offset_o     (offset_o)
    );

    always #5 byte_clk_i = ~byte_clk_i;

    int tests_run = 0;
    int tests_failed = 0;
    int found_seen, err_seen;

    // Reference model: whole lane stream kept as a bit queue, LSB-first
    bit         stream_q[$];
    int         m_mode, m_cnt, m_off, m_sync_pos, m_pay_n;
    logic [7:0] m_byte;
    bit         m_valid, m_found, m_err;
    logic [7:0] pay_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        stream_q.delete();
        for (int j = 0; j < 8; j++) stream_q.push_back(1'b0);
        m_mode = MD_IDLE; m_cnt = 0; m_off = 0; m_sync_pos = 0; m_pay_n = 0;
        m_byte = 8'h00; m_valid = 1'b0; m_found = 1'b0; m_err = 1'b0;
    endtask

    function automatic int find_sync(input int base);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) v[j] = stream_q[base + k + j];
            if (v == 8'hB8) return k;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit en, input logic [7:0] d);
        int base, k;
        base = stream_q.size() - 8;
        for (int j = 0; j < 8; j++) stream_q.push_back(d[j]);
        m_found = 1'b0; m_err = 1'b0; m_valid = 1'b0;
        if (!en) begin
            m_mode = MD_IDLE; m_cnt = 0;
        end else if (m_mode == MD_IDLE) begin
            m_mode = MD_SEARCH; m_cnt = 0;
        end else if (m_mode == MD_SEARCH) begin
            k = find_sync(base);
            if (k >= 0) begin
                m_mode = MD_ALIGNED; m_off = k; m_found = 1'b1;
                m_sync_pos = base + k; m_pay_n = 0;
            end else begin
                m_cnt++;
                if (m_cnt >= TO) begin
                    m_mode = MD_TIMEOUT; m_err = 1'b1;
                end
            end
        end else if (m_mode == MD_ALIGNED) begin
            // Payload byte n sits 8*(n+1) bits past the start of the sync byte
            for (int j = 0; j < 8; j++) m_byte[j] = stream_q[m_sync_pos + 8 * (m_pay_n + 1) + j];
            m_pay_n++;
            m_valid = 1'b1;
        end
    endtask

    task automatic step(input bit en, input logic [7:0] d);
        @(negedge byte_clk_i);
        enable_i = en;
        byte_data_i = d;
        @(posedge byte_clk_i);
        model_edge(en, d);
        #1;
        if (sync_found_o) found_seen++;
        if (sync_err_o) err_seen++;
        check_val("valid", 32'(valid_o), 32'(m_valid));
        check_val("sync_found", 32'(sync_found_o), 32'(m_found));
        check_val("sync_err", 32'(sync_err_o), 32'(m_err));
        check_val("offset", 32'(offset_o), 32'(m_off));
        check_val("byte", 32'(byte_o), 32'(m_byte));
    endtask

    // Pack zbits zeros, the sync byte and pay_q LSB-first into bytes and send them
    task automatic send_burst(input int zbits, input int drop_at);
        bit         bq[$];
        logic [7:0] sv, v;
        sv = 8'hB8;
        for (int i = 0; i < zbits; i++) bq.push_back(1'b0);
        for (int j = 0; j < 8; j++) bq.push_back(sv[j]);
        foreach (pay_q[p]) begin
            v = pay_q[p];
            for (int j = 0; j < 8; j++) bq.push_back(v[j]);
        end
        while (bq.size() % 8 != 0) bq.push_back(1'b0);
        for (int j = 0; j < 8; j++) bq.push_back(1'b0);
        for (int b = 0; b < bq.size() / 8; b++) begin
            for (int j = 0; j < 8; j++) v[j] = bq[8 * b + j];
            step((b == drop_at) ? 1'b0 : 1'b1, v);
        end
    endtask

    task automatic async_reset();
        #1 rst_i = 1'b1;
        #1;
        check_val("rst_valid", 32'(valid_o), 32'd0);
        check_val("rst_byte", 32'(byte_o), 32'd0);
        check_val("rst_offset", 32'(offset_o), 32'd0);
        check_val("rst_found", 32'(sync_found_o), 32'd0);
        check_val("rst_err", 32'(sync_err_o), 32'd0);
        model_reset();
        @(posedge byte_clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        int kind, len;
        rst_i = 1'b1; enable_i = 1'b0; byte_data_i = 8'h00;
        found_seen = 0; err_seen = 0;
        model_reset();
        #1;
        check_val("init_valid", 32'(valid_o), 32'd0);
        check_val("init_offset", 32'(offset_o), 32'd0);
        check_val("init_byte", 32'(byte_o), 32'd0);
        repeat (2) @(posedge byte_clk_i);
        #1 rst_i = 1'b0;

        // Offset 0: 00,00,B8,11,22
        pay_q = '{8'h11, 8'h22};
        found_seen = 0;
        send_burst(16, -1);
        check_val("off0_offset", 32'(offset_o), 32'd0);
        check_val("off0_found_cnt", 32'(found_seen), 32'd1);
        step(1'b0, 8'h00);

        // Offset 3: 19 zero bits, then B8,A5,3C
        pay_q = '{8'hA5, 8'h3C};
        send_burst(19, -1);
        check_val("off3_offset", 32'(offset_o), 32'd3);
        step(1'b0, 8'h00);

        // Timeout, then the aligner must ignore syncs until enable drops
        err_seen = 0; found_seen = 0;
        repeat (41) step(1'b1, 8'h00);
        repeat (4) step(1'b1, 8'hB8);
        check_val("timeout_err_cnt", 32'(err_seen), 32'd1);
        check_val("timeout_found_cnt", 32'(found_seen), 32'd0);
        step(1'b0, 8'h00);

        // Burst restart: offset 0 then offset 5
        pay_q = '{8'h5A, 8'hC3, 8'h0F};
        send_burst(16, -1);
        step(1'b0, 8'h00);
        check_val("restart_valid", 32'(valid_o), 32'd0);
        pay_q = '{8'h96, 8'h71};
        send_burst(21, -1);
        check_val("restart_offset", 32'(offset_o), 32'd5);
        step(1'b0, 8'h00);

        // Async reset mid-ALIGNED, then re-sync at offset 2
        pay_q = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_burst(16, 5);
        pay_q = '{8'hDE, 8'hAD};
        send_burst(16, -1);
        async_reset();
        pay_q = '{8'hBE, 8'hEF};
        send_burst(18, -1);
        check_val("post_rst_offset", 32'(offset_o), 32'd2);
        step(1'b0, 8'h00);

        // Match coinciding with enable low
        found_seen = 0;
        step(1'b1, 8'h00);
        step(1'b1, 8'hB8);
        step(1'b0, 8'h11);
        step(1'b0, 8'h22);
        check_val("en_low_match_found", 32'(found_seen), 32'd0);

        // Randomized bursts
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 5);
            if (kind <= 2) begin
                pay_q.delete();
                len = $urandom_range(1, 6);
                for (int p = 0; p < len; p++) pay_q.push_back(8'($urandom));
                send_burst($urandom_range(8, 40), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -1);
            end else if (kind <= 4) begin
                len = $urandom_range(1, 45);
                for (int b = 0; b < len; b++) step(1'b1, 8'($urandom));
            end else begin
                pay_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
                send_burst($urandom_range(8, 24), -1);
                async_reset();
            end
            repeat ($urandom_range(1, 2)) step(1'b0, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
